// File: rtl/compare_result_tracker.sv
// Decodes max-comparator winner flags into a registered result slot
// and keeps saturating win/tie counts, streak length and a sticky alarm.
module compare_result_tracker #(
    parameter int CNT_W     = 8,
    parameter int STREAK_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             agt,
    input  logic             bgt,
    input  logic             cgt,
    input  logic             dgt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       win_idx,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b,
    output logic [CNT_W-1:0] cnt_c,
    output logic [CNT_W-1:0] cnt_d,
    output logic [CNT_W-1:0] cnt_tie,
    output logic [CNT_W-1:0] streak_len,
    output logic             alarm
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TH      = CNT_W'(STREAK_TH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    slot_t            state_q;
    slot_t            state_d;
    logic             accept;
    logic [3:0]       flags;
    logic             dec_one;
    logic             dec_tie;
    logic             dec_err;
    logic [1:0]       dec_idx;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] streak_q;
    logic [CNT_W-1:0] streak_d;
    logic [1:0]       last_q;
    logic             alarm_q;
    logic [1:0]       idx_q;
    logic             tie_q;
    logic             err_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    assign flags = {agt, bgt, cgt, dgt};

    always_comb begin
        dec_one = 1'b0;
        dec_tie = 1'b0;
        dec_err = 1'b0;
        dec_idx = 2'd0;
        case (flags)
            4'b1000: begin dec_one = 1'b1; dec_idx = 2'd0; end
            4'b0100: begin dec_one = 1'b1; dec_idx = 2'd1; end
            4'b0010: begin dec_one = 1'b1; dec_idx = 2'd2; end
            4'b0001: begin dec_one = 1'b1; dec_idx = 2'd3; end
            4'b1111: dec_tie = 1'b1;
            default: dec_err = 1'b1;
        endcase
    end

    // Slot may be refilled in the same cycle it drains.
    always_comb begin
        state_d  = state_q;
        in_ready = !clear && (state_q == EMPTY || out_ready);
        accept   = in_valid && in_ready;
        if (clear)
            state_d = EMPTY;
        else if (accept)
            state_d = FULL;
        else if (out_ready)
            state_d = EMPTY;
    end

    always_comb begin
        streak_d = '0;
        if (dec_one) begin
            if (dec_idx == last_q && streak_q != '0)
                streak_d = sat_inc(streak_q);
            else
                streak_d = ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 5; i++)
                cnt_q[i] <= '0;
            streak_q <= '0;
            last_q   <= 2'd0;
            alarm_q  <= 1'b0;
            idx_q    <= 2'd0;
            tie_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < 5; i++)
                cnt_q[i] <= '0;
            streak_q <= '0;
            last_q   <= 2'd0;
            alarm_q  <= 1'b0;
            idx_q    <= 2'd0;
            tie_q    <= 1'b0;
            err_q    <= 1'b0;
        end else if (accept) begin
            idx_q    <= dec_idx;
            tie_q    <= dec_tie;
            err_q    <= dec_err;
            streak_q <= streak_d;
            if (dec_one) begin
                cnt_q[dec_idx] <= sat_inc(cnt_q[dec_idx]);
                last_q         <= dec_idx;
            end
            if (dec_tie)
                cnt_q[4] <= sat_inc(cnt_q[4]);
            if (streak_d == TH)
                alarm_q <= 1'b1;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign win_idx    = idx_q;
    assign tie        = tie_q;
    assign err        = err_q;
    assign cnt_a      = cnt_q[0];
    assign cnt_b      = cnt_q[1];
    assign cnt_c      = cnt_q[2];
    assign cnt_d      = cnt_q[3];
    assign cnt_tie    = cnt_q[4];
    assign streak_len = streak_q;
    assign alarm      = alarm_q;

endmodule

// File: tb/tb_compare_result_tracker.sv
// Randomized and directed bench for compare_result_tracker against a
// behavioural model; runs an 8-bit and a 2-bit counter instance in lockstep.
module tb_compare_result_tracker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] flags = 4'b0;

    logic       in_ready8, out_valid8, tie8, err8, alarm8;
    logic [1:0] win_idx8;
    logic [7:0] cnt_a8, cnt_b8, cnt_c8, cnt_d8, cnt_tie8, streak8;

    logic       in_ready2, out_valid2, tie2, err2, alarm2;
    logic [1:0] win_idx2;
    logic [1:0] cnt_a2, cnt_b2, cnt_c2, cnt_d2, cnt_tie2, streak2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    compare_result_tracker #(.CNT_W(8), .STREAK_TH(4)) dut8 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready8),
        .agt(flags[3]), .bgt(flags[2]), .cgt(flags[1]), .dgt(flags[0]),
        .out_valid(out_valid8), .out_ready(out_ready),
        .win_idx(win_idx8), .tie(tie8), .err(err8),
        .cnt_a(cnt_a8), .cnt_b(cnt_b8), .cnt_c(cnt_c8), .cnt_d(cnt_d8),
        .cnt_tie(cnt_tie8), .streak_len(streak8), .alarm(alarm8)
    );

    compare_result_tracker #(.CNT_W(2), .STREAK_TH(3)) dut2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready2),
        .agt(flags[3]), .bgt(flags[2]), .cgt(flags[1]), .dgt(flags[0]),
        .out_valid(out_valid2), .out_ready(out_ready),
        .win_idx(win_idx2), .tie(tie2), .err(err2),
        .cnt_a(cnt_a2), .cnt_b(cnt_b2), .cnt_c(cnt_c2), .cnt_d(cnt_d2),
        .cnt_tie(cnt_tie2), .streak_len(streak2), .alarm(alarm2)
    );

    // Behavioural model; index k=0 is the 8-bit instance, k=1 the 2-bit one.
    int  m_cnt [2][5];
    int  m_streak [2];
    int  m_last [2];
    bit  m_alarm [2];
    bit  m_valid;
    int  m_idx;
    bit  m_tie;
    bit  m_err;
    int  maxv [2] = '{255, 3};
    int  th [2] = '{4, 3};

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 5; j++) m_cnt[k][j] = 0;
            m_streak[k] = 0;
            m_last[k] = 0;
            m_alarm[k] = 0;
        end
        m_valid = 0;
        m_idx = 0;
        m_tie = 0;
        m_err = 0;
    endtask

    task automatic model_edge();
        int n;
        if (clear) begin
            model_reset();
        end else if (in_valid && (!m_valid || out_ready)) begin
            n = $countones(flags);
            m_tie = (flags == 4'hF);
            m_err = !(n == 1 || m_tie);
            m_idx = 0;
            if (n == 1)
                for (int i = 0; i < 4; i++)
                    if (flags[3-i]) m_idx = i;
            for (int k = 0; k < 2; k++) begin
                if (n == 1) begin
                    if (m_cnt[k][m_idx] < maxv[k]) m_cnt[k][m_idx]++;
                    if (m_streak[k] > 0 && m_last[k] == m_idx) begin
                        if (m_streak[k] < maxv[k]) m_streak[k]++;
                    end else begin
                        m_streak[k] = 1;
                    end
                    m_last[k] = m_idx;
                end else begin
                    if (m_tie && m_cnt[k][4] < maxv[k]) m_cnt[k][4]++;
                    m_streak[k] = 0;
                end
                if (m_streak[k] == th[k]) m_alarm[k] = 1;
            end
            m_valid = 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
    endtask

    function automatic logic [63:0] exp_vec(int k);
        return {10'b0, m_valid, 2'(m_idx), m_tie, m_err,
                8'(m_cnt[k][0]), 8'(m_cnt[k][1]), 8'(m_cnt[k][2]),
                8'(m_cnt[k][3]), 8'(m_cnt[k][4]), 8'(m_streak[k]),
                m_alarm[k]};
    endfunction

    function automatic logic [63:0] obs_vec(int k);
        if (k == 0)
            return {10'b0, out_valid8, win_idx8, tie8, err8, cnt_a8, cnt_b8,
                    cnt_c8, cnt_d8, cnt_tie8, streak8, alarm8};
        return {10'b0, out_valid2, win_idx2, tie2, err2, 6'b0, cnt_a2,
                6'b0, cnt_b2, 6'b0, cnt_c2, 6'b0, cnt_d2, 6'b0, cnt_tie2,
                6'b0, streak2, alarm2};
    endfunction

    task automatic drive(bit v, logic [3:0] f, bit ordy, bit clr);
        in_valid = v;
        flags = f;
        out_ready = ordy;
        clear = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(0, 4'b0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL reset_state[%0d]: got %h want %h", k, obs_vec(k), exp_vec(k));
            end
        end
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready8);
        end
    endtask

    task automatic test_first_result();
        drive(1, 4'b0010, 1, 0);
        tick();
        drive(0, 4'b0, 0, 0);
        checks++;
        if ({out_valid8, win_idx8, cnt_c8, streak8} !== {1'b1, 2'd2, 8'd1, 8'd1}) begin
            errors++;
            $display("FAIL first_result: got %b/%0d/%0d/%0d want 1/2/1/1",
                     out_valid8, win_idx8, cnt_c8, streak8);
        end
        checks++;
        if (obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL first_vec: got %h want %h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_streak();
        drive(0, 4'b0, 1, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b0100, 1, 0);
            tick();
            checks++;
            if (streak8 !== 8'(i + 1) || obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL streak_step%0d: got len %0d vec %h want len %0d vec %h",
                         i, streak8, obs_vec(0), i + 1, exp_vec(0));
            end
        end
        checks++;
        if (alarm8 !== 1'b1) begin
            errors++;
            $display("FAIL streak_alarm: got %b want 1", alarm8);
        end
        drive(1, 4'b1111, 1, 0);
        tick();
        checks++;
        if ({tie8, cnt_tie8, streak8, alarm8} !== {1'b1, 8'd1, 8'd0, 1'b1}
            || obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL tie_after_streak: got %h want %h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_illegal();
        logic [3:0] pats [3] = '{4'b0000, 4'b1100, 4'b0111};
        for (int i = 0; i < 3; i++) begin
            drive(1, pats[i], 1, 0);
            tick();
            checks++;
            if (err8 !== 1'b1 || streak8 !== 8'd0 || obs_vec(0) !== exp_vec(0)) begin
                errors++;
                $display("FAIL illegal_%b: got %h want %h", pats[i], obs_vec(0), exp_vec(0));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] held;
        drive(1, 4'b0001, 1, 0);
        tick();
        held = exp_vec(0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'($urandom_range(15)), 0, 0);
            #1;
            checks++;
            if (in_ready8 !== 1'b0) begin
                errors++;
                $display("FAIL bp_in_ready%0d: got %b want 0", i, in_ready8);
            end
            tick();
            checks++;
            if (obs_vec(0) !== held) begin
                errors++;
                $display("FAIL bp_hold%0d: got %h want %h", i, obs_vec(0), held);
            end
        end
        drive(1, 4'b1000, 1, 0);
        #1;
        checks++;
        if (in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", in_ready8);
        end
        tick();
        checks++;
        if (out_valid8 !== 1'b1 || win_idx8 !== 2'd0 || obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL bp_release: got %h want %h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
        drive(0, 4'b0, 1, 1);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 4'b1000, 1, 0);
            tick();
            checks++;
            if (cnt_a2 !== want[i] || streak2 !== want[i] || obs_vec(1) !== exp_vec(1)) begin
                errors++;
                $display("FAIL sat_step%0d: got cnt %0d len %0d want %0d",
                         i, cnt_a2, streak2, want[i]);
            end
        end
    endtask

    task automatic test_clear();
        for (int i = 0; i < 4; i++) begin
            drive(1, 4'b0010, 1, 0);
            tick();
        end
        drive(1, 4'b0001, 0, 1);
        #1;
        checks++;
        if (in_ready8 !== 1'b0 || alarm8 !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre: got ready %b alarm %b want 0 1", in_ready8, alarm8);
        end
        tick();
        drive(0, 4'b0, 0, 0);
        checks++;
        if (out_valid8 !== 1'b0 || alarm8 !== 1'b0 || cnt_d8 !== 8'd0
            || obs_vec(0) !== exp_vec(0)) begin
            errors++;
            $display("FAIL clear_post: got %h want %h", obs_vec(0), exp_vec(0));
        end
    endtask

    task automatic test_random();
        bit         v, ordy, clr, want_rdy;
        logic [3:0] f;
        int         last = 0;
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(3) != 0);
            ordy = ($urandom_range(3) != 0);
            clr = ($urandom_range(39) == 0);
            if ($urandom_range(1) == 0) begin
                if ($urandom_range(1) == 0) last = $urandom_range(3);
                f = 4'b1000 >> last;
            end else begin
                f = 4'($urandom_range(15));
            end
            drive(v, f, ordy, clr);
            want_rdy = !clr && (!m_valid || ordy);
            #1;
            checks++;
            if (in_ready8 !== want_rdy || in_ready2 !== want_rdy) begin
                errors++;
                $display("FAIL rand_ready%0d: got %b/%b want %b", n, in_ready8, in_ready2, want_rdy);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (obs_vec(k) !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL rand_vec%0d[%0d]: got %h want %h", n, k, obs_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'b0100, 1, 0);
            tick();
        end
        drive(1, 4'b0100, 0, 0);
        @(negedge clk);
        #2;
        rst = 1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (obs_vec(k) !== exp_vec(k)) begin
                errors++;
                $display("FAIL rst_async[%0d]: got %h want %h", k, obs_vec(k), exp_vec(k));
            end
        end
        drive(0, 4'b0, 1, 0);
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got ready %b valid %b want 1 0", in_ready8, out_valid8);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_result();
        test_streak();
        test_illegal();
        test_backpressure();
        test_saturate();
        test_clear();
        test_random();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/compare_result_tracker.md
# compare_result_tracker

Registered consumer that sits directly downstream of the four-input maximum comparator. It accepts the comparator's winner flags (`agt`, `bgt`, `cgt`, `dgt`) through a valid/ready handshake and decodes them into a winner index with tie and error indication. It keeps saturating per-input win counters and a tie counter, and tracks consecutive-winner streaks with a sticky alarm. Its output is a single-entry registered result presented to the next stage under valid/ready.

## Interface
- `CNT_W`, default 8: width of every win/tie counter and of the streak counter.
- `STREAK_TH`, default 4: streak length that sets the alarm. Legal range is 1..2^CNT_W-1.

- `clk` (in, 1): the single clock; all state updates on the rising edge.
- `rst` (in, 1): asynchronous, active-high reset. Asserting it forces every register to its reset value immediately.
- `clear` (in, 1): synchronous clear of the statistics and of the output slot.
- `in_valid` (in, 1): flags on the inputs below are valid.
- `in_ready` (out, 1): the block can accept the flags this cycle.
- `agt`, `bgt`, `cgt`, `dgt` (in, 1 each): winner flags from the comparator.
- `out_valid` (out, 1): the result registers hold an undelivered result.
- `out_ready` (in, 1): the downstream stage takes the result.
- `win_idx` (out, 2): winner index, a=0, b=1, c=2, d=3.
- `tie` (out, 1): the result was the all-four-equal pattern.
- `err` (out, 1): the result was an illegal flag pattern.
- `cnt_a`, `cnt_b`, `cnt_c`, `cnt_d` (out, CNT_W each): saturating win counts.
- `cnt_tie` (out, CNT_W): saturating tie count.
- `streak_len` (out, CNT_W): current consecutive-winner run length.
- `alarm` (out, 1): sticky; set when `streak_len` reaches `STREAK_TH`.

## Operation
- The output slot is a 2-state machine:
  - EMPTY → FULL on accept.
  - FULL → EMPTY on `out_ready` with no accept.
  - FULL stays FULL on `out_ready` plus accept; the slot is replaced in the same cycle.
- `in_ready` = !`clear` && (EMPTY || `out_ready`). An accept is `in_valid` && `in_ready`.
- Flag decode for an accepted pattern (flags listed as `{agt,bgt,cgt,dgt}`):
  - One-hot pattern: `win_idx` = the index of the set flag; `tie`=0, `err`=0.
  - 1111: `tie`=1, `win_idx`=0, `err`=0.
  - Any other pattern (0000, or 2 or 3 bits set): `err`=1, `tie`=0, `win_idx`=0.
- Counter updates on accept:
  - One-hot: the matching `cnt_x` increments by 1 and holds at 2^CNT_W-1.
  - Tie: `cnt_tie` increments with the same saturation.
  - Err: no counter changes.
- Streak updates on accept:
  - One-hot with the same index as the last one-hot winner, and `streak_len` nonzero: `streak_len` increments, saturating.
  - One-hot otherwise: `streak_len`=1 and the stored last winner is updated.
  - Tie or err: `streak_len`=0.
- `alarm` sets on the edge where the updated `streak_len` equals `STREAK_TH`. It stays set until `clear` or `rst`.
- `clear`, same edge: all counters, `streak_len`, the stored last winner and `alarm` go to 0, and the slot goes to EMPTY. `in_ready` is 0 that cycle, so an input presented with `clear` is not accepted.
- While FULL and not taken, `win_idx`, `tie` and `err` hold stable.
- `rst` mid-operation: any pending result is discarded; there is no recovery of in-flight data.

## Timing
- Reset values: `out_valid`=0, `win_idx`=0, `tie`=0, `err`=0, every counter 0, `streak_len`=0, `alarm`=0. `in_ready`=1 once `rst` deasserts, provided `clear`=0.
- Latency is 1 cycle: flags accepted at edge N appear with `out_valid`=1 after edge N. Counters, streak and alarm also reflect the sample after edge N.
- Full throughput: with `out_ready` held at 1, one result is accepted per cycle with no bubbles.
- Back-pressure: with `out_ready`=0 and the slot FULL, `in_ready`=0 and the inputs are ignored.
- `in_ready` depends combinationally on `out_ready` and `clear`. No other combinational input-to-output path exists.

## Test plan
- Reset, then `{agt,bgt,cgt,dgt}`=0010 with `in_valid`=1 for 1 cycle and `out_ready`=1 → next cycle `out_valid`=1, `win_idx`=2, `cnt_c`=1, `streak_len`=1; all other counters 0.
- Four back-to-back 0100 accepts with `STREAK_TH`=4 → `streak_len` steps 1,2,3,4, `alarm`=1 after the 4th and stays 1. A following 1111 gives `tie`=1, `cnt_tie`=1, `streak_len`=0, `alarm` still 1.
- Illegal patterns 0000, then 1100, then 0111 → `err`=1 on each result, all counters unchanged, `streak_len`=0.
- `out_ready`=0 with the slot FULL, `in_valid`=1 for 3 cycles → `in_ready`=0, and the held result plus all counters stay unchanged. Raising `out_ready` → 1 transfer, and the new input is accepted in the same cycle.
- `CNT_W`=2, six 1000 accepts → `cnt_a` reads 1,2,3,3,3,3 and `streak_len` saturates at 3.
- `clear` asserted together with `in_valid` and 0001 while FULL → that input is not accepted; after the edge `out_valid`=0, all counters 0, `alarm`=0. Separately, `rst` pulsed mid-stream clears all outputs immediately without waiting for a clock edge.
